// File: rtl/rf_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// rf_writeback_ctrl
//
// Write-side initiator for the 32-entry general-purpose register file. ALU
// results and load returns share the file's single write port (WE3/A3/WD3).
// ALU results go straight to the port; load returns wait in a small FIFO and
// retire in slots the ALU leaves free. This block also handles:
//   - same-register ordering (an ALU write kills older queued loads to that rd)
//   - x0 write suppression on both sources
//   - load anti-starvation (a load is forced after STARVE_MAX blocked cycles)
//   - a combinational forwarding lookup into pending load data
// Because of this, the register file itself stays a plain storage array.
//
// Parameters
//   N           data width, matches the register file width
//   DEPTH       load-return FIFO entries (power of 2, >= 2)
//   STARVE_MAX  blocked cycles tolerated before a queued load is forced
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   i_alu_valid/o_alu_ready  ALU result handshake
//   i_alu_rd, i_alu_data     ALU destination and result
//   i_ld_valid/o_ld_ready    load-return handshake (ready = FIFO not full)
//   i_ld_rd, i_ld_data       load destination and data
//   o_we3, o_a3, o_wd3       registered register-file write port
//   i_q_rd                   forwarding query address
//   o_q_hit, o_q_data        youngest valid queued load to i_q_rd (comb.)
//   o_fifo_count             occupied FIFO entries, valid or killed
// -----------------------------------------------------------------------------
module rf_writeback_ctrl #(
  parameter int N          = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     i_alu_valid,
  output logic                     o_alu_ready,
  input  logic [4:0]               i_alu_rd,
  input  logic [N-1:0]             i_alu_data,

  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [4:0]               i_ld_rd,
  input  logic [N-1:0]             i_ld_data,

  output logic                     o_we3,
  output logic [4:0]               o_a3,
  output logic [N-1:0]             o_wd3,

  input  logic [4:0]               i_q_rd,
  output logic                     o_q_hit,
  output logic [N-1:0]             o_q_data,

  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO storage. Valid bits are kept only for occupied slots: they are set on
  // enqueue and cleared on dequeue or kill, so "any valid bit set" means
  // "some queued load still has to be written".
  logic [N-1:0]     r_data [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;

  logic             r_we3;
  logic [4:0]       r_a3;
  logic [N-1:0]     r_wd3;

  logic             w_force;
  logic             w_alu_acc;
  logic             w_alu_wr;
  logic             w_ld_acc;
  logic             w_enq;
  logic             w_nonempty;
  logic             w_head_vld;
  logic             w_ld_ret;
  logic             w_deq;
  logic             w_any_vld;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_q_hit;
  logic [N-1:0]     w_q_data;

  // Handshakes and slot arbitration (cycle t, acceptance)
  // A forced load owns the slot outright, so the ALU is simply told it is not
  // ready; that keeps the ALU path free of any "accepted but lost" case.
  assign w_force     = (r_starve == SW'(STARVE_MAX));
  assign o_alu_ready = !rst && !w_force;
  // Ready looks at the registered count only, so a full FIFO refuses new
  // loads even in a cycle where its head drains.
  assign o_ld_ready  = !rst && (r_count < CW'(DEPTH));

  assign w_alu_acc   = i_alu_valid && o_alu_ready;
  assign w_alu_wr    = w_alu_acc && (i_alu_rd != 5'd0);
  assign w_ld_acc    = i_ld_valid && o_ld_ready;
  assign w_enq       = w_ld_acc && (i_ld_rd != 5'd0);

  assign w_nonempty  = (r_count != '0);
  assign w_head_vld  = w_nonempty && r_vld[r_head];
  // The ALU can never win during a forced cycle (ready is low), so "head is
  // valid and the ALU is not writing" covers both the forced and free cases.
  assign w_ld_ret    = w_head_vld && !w_alu_wr;
  // A killed head is discarded without using the write slot.
  assign w_deq       = w_nonempty && (!r_vld[r_head] || w_ld_ret);

  assign w_any_vld   = |r_vld;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_force || w_ld_ret || !w_nonempty) begin
      w_starve_nxt = '0;
    end else if (w_any_vld && w_alu_wr) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Forwarding lookup: walk oldest to youngest so the last match wins.
  always_comb begin
    w_q_hit  = 1'b0;
    w_q_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_q_rd != 5'd0 && r_vld[r_head + PW'(k)] &&
          r_rd[r_head + PW'(k)] == i_q_rd) begin
        w_q_hit  = 1'b1;
        w_q_data = r_data[r_head + PW'(k)];
      end
    end
  end

  assign o_q_hit  = w_q_hit;
  assign o_q_data = w_q_data;

  // FIFO control state (end of cycle t)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;

      // Kill first: older queued loads to the ALU's rd must never land after
      // the ALU result. A load enqueued on this same edge is younger and its
      // valid bit is set below, overriding the kill.
      if (w_alu_wr) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (r_rd[k] == i_alu_rd) begin
            r_vld[k] <= 1'b0;
          end
        end
      end

      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end

      // The tail slot is free whenever an enqueue is possible, so it can never
      // collide with the head clear above.
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end

      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload needs no reset: it is only observed through the valid bits.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_tail]   <= i_ld_rd;
      r_data[r_tail] <= i_ld_data;
    end
  end

  // Write port register (cycle t+1, visible to the register file)
  // Address and data only move on a write so they hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_alu_wr) begin
      r_we3 <= 1'b1;
      r_a3  <= i_alu_rd;
      r_wd3 <= i_alu_data;
    end else if (w_ld_ret) begin
      r_we3 <= 1'b1;
      r_a3  <= r_rd[r_head];
      r_wd3 <= r_data[r_head];
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign o_we3        = r_we3;
  assign o_a3         = r_a3;
  assign o_wd3        = r_wd3;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
module tb_rf_writeback_ctrl;

  localparam int N          = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid, alu_ready;
  logic [4:0]    alu_rd;
  logic [N-1:0]  alu_data;
  logic          ld_valid, ld_ready;
  logic [4:0]    ld_rd;
  logic [N-1:0]  ld_data;
  logic          we3;
  logic [4:0]    a3;
  logic [N-1:0]  wd3;
  logic [4:0]    q_rd;
  logic          q_hit;
  logic [N-1:0]  q_data;
  logic [2:0]    fifo_count;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] sb [$];

  rf_writeback_ctrl #(.N(N), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_alu_valid  (alu_valid),
    .o_alu_ready  (alu_ready),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_ld_valid   (ld_valid),
    .o_ld_ready   (ld_ready),
    .i_ld_rd      (ld_rd),
    .i_ld_data    (ld_data),
    .o_we3        (we3),
    .o_a3         (a3),
    .o_wd3        (wd3),
    .i_q_rd       (q_rd),
    .o_q_hit      (q_hit),
    .o_q_data     (q_data),
    .o_fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ew(input logic [4:0] rd, input logic [31:0] d);
    return {27'd0, rd, d};
  endfunction

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  // Next drive point: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write on the port must match the oldest expectation.
  always @(negedge clk) begin
    if (we3) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, a3, wd3}, 64'd0);
      end else begin
        chk("write", {27'd0, a3, wd3}, sb.pop_front());
      end
    end
  end

  initial begin
    alu(0, 0, 0);
    ld(0, 0, 0);
    q_rd = 0;

    // reset state
    @(negedge clk);
    chk("rst_we3", we3, 0);
    chk("rst_a3", a3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_qhit", q_hit, 0);
    chk("rst_qdata", q_data, 0);
    chk("rst_alurdy", alu_ready, 0);
    chk("rst_ldrdy", ld_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rel_alurdy", alu_ready, 1);
    chk("rel_ldrdy", ld_ready, 1);
    cyc();

    // ALU only, then x0 on both sources
    alu(1, 5, 32'hDEADBEEF);
    sb.push_back(ew(5, 32'hDEADBEEF));
    @(negedge clk);
    cyc();
    alu(1, 0, 32'h1234);
    ld(1, 0, 32'h5555);
    @(negedge clk);
    chk("alu_we3", we3, 1);
    chk("alu_a3", a3, 5);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    cyc();
    alu(0, 0, 0);
    ld(0, 0, 0);
    @(negedge clk);
    chk("x0_we3", we3, 0);
    chk("hold_a3", a3, 5);
    chk("hold_wd3", wd3, 32'hDEADBEEF);
    chk("x0_ld_cnt", fifo_count, 0);
    cyc();

    // fill the FIFO while the ALU owns every slot
    for (int k = 0; k < 5; k++) begin
      alu(1, 5'(10 + k), 32'h1000 + k);
      sb.push_back(ew(5'(10 + k), 32'h1000 + k));
      if (k < 4) ld(1, 5'(1 + k), 32'h100 + k);
      else       ld(0, 0, 0);
      @(negedge clk);
      if (k == 4) begin
        chk("full_cnt", fifo_count, 4);
        chk("full_ldrdy", ld_ready, 0);
      end
      cyc();
    end
    alu(0, 0, 0);
    ld(1, 30, 32'h3030);
    for (int k = 0; k < 4; k++) sb.push_back(ew(5'(1 + k), 32'h100 + k));
    @(negedge clk);
    chk("full_deq_ldrdy", ld_ready, 0);
    cyc();
    ld(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ld_b2b_we3", we3, 1);
      cyc();
    end
    @(negedge clk);
    chk("drained_cnt", fifo_count, 0);
    cyc();

    // kill: ALU write to x7 overrides an older queued load to x7
    alu(1, 20, 32'h2020);
    ld(1, 7, 32'h11);
    sb.push_back(ew(20, 32'h2020));
    q_rd = 7;
    cyc();
    alu(1, 7, 32'h22);
    ld(0, 0, 0);
    sb.push_back(ew(7, 32'h22));
    @(negedge clk);
    chk("kill_qhit_pre", q_hit, 1);
    chk("kill_qdata_pre", q_data, 32'h11);
    cyc();
    alu(0, 0, 0);
    @(negedge clk);
    chk("kill_qhit_post", q_hit, 0);
    chk("kill_qdata_post", q_data, 0);
    chk("kill_cnt", fifo_count, 1);
    cyc();
    @(negedge clk);
    chk("kill_popped_cnt", fifo_count, 0);
    cyc();
    repeat (2) cyc();

    // starvation: ALU never lets go
    alu(1, 21, 32'h2100);
    ld(1, 9, 32'h99);
    sb.push_back(ew(21, 32'h2100));
    cyc();
    ld(0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      alu(1, 5'(22 + (k % 8)), 32'h3000 + k);
      if (k != 9) sb.push_back(ew(5'(22 + (k % 8)), 32'h3000 + k));
      else        sb.push_back(ew(9, 32'h99));
      @(negedge clk);
      chk("starve_alurdy", alu_ready, (k != 9));
      cyc();
    end
    alu(0, 0, 0);
    repeat (3) cyc();

    // forwarding: youngest match wins, x0 never hits
    q_rd = 3;
    alu(1, 15, 32'h1500);
    ld(1, 3, 32'hA);
    sb.push_back(ew(15, 32'h1500));
    cyc();
    alu(1, 16, 32'h1600);
    ld(1, 3, 32'hB);
    sb.push_back(ew(16, 32'h1600));
    @(negedge clk);
    chk("fwd_one_qhit", q_hit, 1);
    chk("fwd_one_qdata", q_data, 32'hA);
    cyc();
    alu(1, 17, 32'h1700);
    ld(0, 0, 0);
    sb.push_back(ew(17, 32'h1700));
    @(negedge clk);
    chk("fwd_cnt", fifo_count, 2);
    chk("fwd_young_qhit", q_hit, 1);
    chk("fwd_young_qdata", q_data, 32'hB);
    q_rd = 0;
    #1;
    chk("fwd_x0_qhit", q_hit, 0);
    chk("fwd_x0_qdata", q_data, 0);
    cyc();
    alu(0, 0, 0);
    sb.push_back(ew(3, 32'hA));
    sb.push_back(ew(3, 32'hB));
    repeat (4) cyc();

    // reset mid-stream with three loads queued
    q_rd = 2;
    for (int k = 0; k < 3; k++) begin
      alu(1, 5'(24 + k), 32'h2400 + k);
      ld(1, 5'(1 + k), 32'h500 + k);
      sb.push_back(ew(5'(24 + k), 32'h2400 + k));
      cyc();
    end
    alu(1, 27, 32'h2700);
    ld(0, 0, 0);
    @(negedge clk);
    chk("mid_cnt", fifo_count, 3);
    chk("mid_qhit", q_hit, 1);
    chk("mid_qdata", q_data, 32'h501);
    #1;
    rst = 1'b1;
    alu(0, 0, 0);
    #1;
    chk("mid_rst_we3", we3, 0);
    chk("mid_rst_a3", a3, 0);
    chk("mid_rst_wd3", wd3, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_qhit", q_hit, 0);
    chk("mid_rst_qdata", q_data, 0);
    chk("mid_rst_alurdy", alu_ready, 0);
    chk("mid_rst_ldrdy", ld_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rel_alurdy", alu_ready, 1);
    chk("mid_rel_ldrdy", ld_ready, 1);
    repeat (6) cyc();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
